// File: rtl/rx_multichan_model.sv
// Multi-channel RX decimation model: per-channel boxcar accumulator feeding
// a first-word-fall-through output FIFO drained over AXI-stream.
module rx_multichan_model #(
    parameter int N_CH         = 2,
    parameter int IN_W         = 16,
    parameter int OUT_W        = 32,
    parameter int RATE_W       = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DEFAULT_RATE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          en_i,
    input  logic [N_CH*RATE_W-1:0]   rate_tdata_i,
    input  logic [N_CH-1:0]          rate_tvalid_i,
    input  logic [N_CH*2*IN_W-1:0]   iq_tdata_i,
    input  logic [N_CH-1:0]          iq_tvalid_i,
    output logic [N_CH*2*OUT_W-1:0]  out_tdata_o,
    output logic [N_CH-1:0]          out_tvalid_o,
    input  logic [N_CH-1:0]          out_tready_i,
    output logic [N_CH-1:0]          overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [RATE_W-1:0]       r_rate;
        logic [RATE_W-1:0]       r_count;
        logic signed [OUT_W-1:0] r_acc_i;
        logic signed [OUT_W-1:0] r_acc_q;
        logic [2*OUT_W-1:0]      r_mem [FIFO_DEPTH];
        logic [AW:0]             r_wptr;
        logic [AW:0]             r_rptr;
        logic                    r_ovf;

        logic [RATE_W-1:0]       w_rate_new;
        logic                    w_rate_wr;
        logic                    w_clr;
        logic [RATE_W-1:0]       w_eff_rate;
        logic [RATE_W-1:0]       w_base_cnt;
        logic signed [OUT_W-1:0] w_base_i;
        logic signed [OUT_W-1:0] w_base_q;
        logic [IN_W-1:0]         w_raw_i;
        logic [IN_W-1:0]         w_raw_q;
        logic signed [OUT_W-1:0] w_in_i;
        logic signed [OUT_W-1:0] w_in_q;
        logic signed [OUT_W-1:0] w_sum_i;
        logic signed [OUT_W-1:0] w_sum_q;
        logic                    w_acc;
        logic                    w_push;
        logic                    w_empty;
        logic                    w_full;
        logic                    w_pop;
        logic                    w_wr;

        assign w_rate_new = rate_tdata_i[c*RATE_W +: RATE_W];
        assign w_rate_wr  = rate_tvalid_i[c] && (w_rate_new != '0);
        assign w_clr      = w_rate_wr || !en_i[c];
        assign w_eff_rate = w_rate_wr ? w_rate_new : r_rate;

        // A rate write or disable discards the partial frame before the sample lands
        assign w_base_cnt = w_clr ? '0 : r_count;
        assign w_base_i   = w_clr ? '0 : r_acc_i;
        assign w_base_q   = w_clr ? '0 : r_acc_q;

        assign w_raw_i = iq_tdata_i[c*2*IN_W +: IN_W];
        assign w_raw_q = iq_tdata_i[c*2*IN_W+IN_W +: IN_W];
        assign w_in_i  = {{(OUT_W-IN_W){w_raw_i[IN_W-1]}}, w_raw_i};
        assign w_in_q  = {{(OUT_W-IN_W){w_raw_q[IN_W-1]}}, w_raw_q};
        assign w_sum_i = w_base_i + w_in_i;
        assign w_sum_q = w_base_q + w_in_q;

        assign w_acc  = en_i[c] && iq_tvalid_i[c];
        assign w_push = w_acc && (w_base_cnt == w_eff_rate - RATE_W'(1));

        assign w_empty = (r_wptr == r_rptr);
        assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_pop   = !w_empty && out_tready_i[c];
        assign w_wr    = w_push && (!w_full || w_pop);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rate  <= RATE_W'(DEFAULT_RATE);
                r_count <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_rate_wr) r_rate <= w_rate_new;
                if (w_acc && w_push) begin
                    r_count <= '0;
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                end else if (w_acc) begin
                    r_count <= w_base_cnt + RATE_W'(1);
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                end else begin
                    r_count <= w_base_cnt;
                    r_acc_i <= w_base_i;
                    r_acc_q <= w_base_q;
                end
                if (!en_i[c]) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_wr)  r_wptr <= r_wptr + 1'b1;
                    if (w_pop) r_rptr <= r_rptr + 1'b1;
                    if (w_push && !w_wr) r_ovf <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_sum_q, w_sum_i};
        end

        assign out_tdata_o[c*2*OUT_W +: 2*OUT_W] =
            w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
        assign out_tvalid_o[c] = !w_empty;
        assign overflow_o[c]   = r_ovf;
    end

endmodule

// File: tb/tb_rx_multichan_model.sv
// Directed bench for rx_multichan_model: vector table plus hand sequences
// for FIFO full/overflow, enable drop and asynchronous reset.
module tb_rx_multichan_model;

    localparam int N_CH = 2;
    localparam int IN_W = 16;
    localparam int OUT_W = 32;
    localparam int RATE_W = 16;
    localparam int FIFO_DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic [N_CH-1:0] en, rv, iv, rdy;
    logic [RATE_W-1:0] rate [N_CH];
    logic [IN_W-1:0] di [N_CH];
    logic [IN_W-1:0] dq [N_CH];
    logic [N_CH*RATE_W-1:0] rate_bus;
    logic [N_CH*2*IN_W-1:0] iq_bus;
    logic [N_CH*2*OUT_W-1:0] out_tdata;
    logic [N_CH-1:0] out_tvalid, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        rate_bus = '0;
        iq_bus = '0;
        for (int c = 0; c < N_CH; c++) begin
            rate_bus[c*RATE_W +: RATE_W] = rate[c];
            iq_bus[c*2*IN_W +: 2*IN_W] = {dq[c], di[c]};
        end
    end

    rx_multichan_model #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .RATE_W(RATE_W),
        .FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_RATE(4)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en),
        .rate_tdata_i(rate_bus), .rate_tvalid_i(rv),
        .iq_tdata_i(iq_bus), .iq_tvalid_i(iv),
        .out_tdata_o(out_tdata), .out_tvalid_o(out_tvalid),
        .out_tready_i(rdy), .overflow_o(ovf)
    );

    function automatic logic [OUT_W-1:0] oi(int c);
        return out_tdata[c*2*OUT_W +: OUT_W];
    endfunction

    function automatic logic [OUT_W-1:0] oq(int c);
        return out_tdata[c*2*OUT_W+OUT_W +: OUT_W];
    endfunction

    task automatic chk(string nm, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rv;
        int   rate;
        logic iv;
        int   i;
        int   q;
        logic rdy;
        logic ev;
        int   ei;
        int   eq;
    } vec_t;

    function automatic vec_t mk(logic a_rv, int a_rate, logic a_iv, int a_i,
                                int a_q, logic a_rdy, logic a_ev, int a_ei, int a_eq);
        vec_t v;
        v.rv = a_rv; v.rate = a_rate; v.iv = a_iv; v.i = a_i; v.q = a_q;
        v.rdy = a_rdy; v.ev = a_ev; v.ei = a_ei; v.eq = a_eq;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        en = '0; rv = '0; iv = '0; rdy = '0;
        for (int c = 0; c < N_CH; c++) begin
            rate[c] = '0; di[c] = '0; dq[c] = '0;
        end

        // R=4 default, I=100 Q=-3
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) tbl.push_back(mk(0, 0, 1, 100, -3, 1, 0, 0, 0));
            tbl.push_back(mk(0, 0, 1, 100, -3, 1, 1, 400, -12));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // R=1 extremes
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(0, 0, 1, -32768, 32767, 1, 1, -32768, 32767));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // rate change mid-frame with same-cycle sample
        tbl.push_back(mk(1, 4, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, -1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, -2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 5, -5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 6, -6, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7, -7, 1, 1, 18, -18));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // zero rate write is ignored; rate stays 3
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 3, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

        step();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("rst_valid%0d", c), OUT_W'(out_tvalid[c]), '0);
            chk($sformatf("rst_data%0d", c), oi(c) | oq(c), '0);
            chk($sformatf("rst_ovf%0d", c), OUT_W'(ovf[c]), '0);
        end
        rst = 1'b0;
        en = '1;
        rdy[1] = 1'b1;
        step();

        foreach (tbl[n]) begin
            rv[0] = tbl[n].rv;
            rate[0] = RATE_W'(tbl[n].rate);
            iv[0] = tbl[n].iv;
            di[0] = IN_W'(tbl[n].i);
            dq[0] = IN_W'(tbl[n].q);
            rdy[0] = tbl[n].rdy;
            step();
            chk($sformatf("vec%0d_valid", n), OUT_W'(out_tvalid[0]), OUT_W'(tbl[n].ev));
            chk($sformatf("vec%0d_i", n), oi(0), OUT_W'(tbl[n].ei));
            chk($sformatf("vec%0d_q", n), oq(0), OUT_W'(tbl[n].eq));
            chk($sformatf("vec%0d_ovf", n), OUT_W'(ovf[0]), '0);
            chk($sformatf("vec%0d_ch1", n), OUT_W'(out_tvalid[1]), '0);
        end

        // Fill FIFO, then push and pop on the same edge while full
        rv[0] = 1'b1; rate[0] = 16'd1; iv[0] = 1'b0; rdy[0] = 1'b0;
        step();
        rv[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            iv[0] = 1'b1; di[0] = IN_W'(k); dq[0] = IN_W'(-k);
            step();
        end
        chk("full_ovf", OUT_W'(ovf[0]), '0);
        chk("full_head_i", oi(0), 32'd1);
        chk("full_head_q", oq(0), 32'hFFFF_FFFF);
        di[0] = 16'd17; dq[0] = IN_W'(-17); rdy[0] = 1'b1;
        step();
        chk("pushpop_ovf", OUT_W'(ovf[0]), '0);
        chk("pushpop_head", oi(0), 32'd2);
        di[0] = 16'd18; dq[0] = IN_W'(-18); rdy[0] = 1'b0;
        step();
        chk("drop_ovf", OUT_W'(ovf[0]), 32'd1);
        chk("drop_head", oi(0), 32'd2);
        iv[0] = 1'b0; rdy[0] = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            chk($sformatf("drain%0d_valid", k), OUT_W'(out_tvalid[0]), 32'd1);
            chk($sformatf("drain%0d_i", k), oi(0), OUT_W'(k));
            chk($sformatf("drain%0d_q", k), oq(0), OUT_W'(-k));
            step();
        end
        chk("drained_valid", OUT_W'(out_tvalid[0]), '0);
        chk("drained_ovf", OUT_W'(ovf[0]), 32'd1);

        // ch0 disabled with words queued; ch1 keeps its own words
        rdy = '0;
        rv[1] = 1'b1; rate[1] = 16'd1;
        step();
        rv[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv = '1;
            di[0] = IN_W'(50 + k); dq[0] = '0;
            di[1] = IN_W'(70 + k); dq[1] = IN_W'(-1);
            step();
        end
        chk("q3_valid0", OUT_W'(out_tvalid[0]), 32'd1);
        chk("q3_head0", oi(0), 32'd50);
        iv[1] = 1'b0;
        en[0] = 1'b0; di[0] = 16'd99;
        step();
        chk("dis_valid0", OUT_W'(out_tvalid[0]), '0);
        chk("dis_ovf0", OUT_W'(ovf[0]), '0);
        chk("dis_data0", oi(0), '0);
        chk("dis_valid1", OUT_W'(out_tvalid[1]), 32'd1);
        chk("dis_head1_i", oi(1), 32'd70);
        chk("dis_head1_q", oq(1), 32'hFFFF_FFFF);
        chk("dis_ovf1", OUT_W'(ovf[1]), '0);
        en[0] = 1'b1; di[0] = 16'd9;
        step();
        chk("reen_valid0", OUT_W'(out_tvalid[0]), 32'd1);
        chk("reen_rate_kept", oi(0), 32'd9);

        // Asynchronous reset between edges
        iv = '0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", OUT_W'(out_tvalid), '0);
        chk("arst_data1", oi(1), '0);
        @(negedge clk);
        rst = 1'b0;
        rdy = '1;
        for (int k = 1; k <= 4; k++) begin
            iv[1] = 1'b1; di[1] = 16'd1; dq[1] = 16'd2;
            step();
            chk($sformatf("defrate_s%0d_valid", k), OUT_W'(out_tvalid[1]), OUT_W'(k == 4));
        end
        chk("defrate_i", oi(1), 32'd4);
        chk("defrate_q", oq(1), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
